// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative restoring divider for DIV/DIVU with pipeline stall request
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous active-low reset
//   start       division request, held high by EX until ready is seen
//   signed_div  1 = signed (DIV), 0 = unsigned (DIVU)
//   dividend    rs operand, captured in IDLE when start=1
//   divisor     rt operand, captured in IDLE when start=1
//   annul       cancel the in-flight division (flush or exception)
//   stop_req    stall request to the pipeline controller
//   ready       result valid this cycle
//   result      {remainder, quotient}

module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  signed_div,
    input  logic [DATA_W-1:0]     dividend,
    input  logic [DATA_W-1:0]     divisor,
    input  logic                  annul,
    output logic                  stop_req,
    output logic                  ready,
    output logic [2*DATA_W-1:0]   result
);

    localparam int CNT_W = $clog2(DATA_W);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BY_ZERO = 2'd1,
        ON      = 2'd2,
        END     = 2'd3
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    // {remainder, quotient}; the quotient bits shift in from the right as
    // the dividend bits shift out into the remainder half.
    logic [2*DATA_W-1:0]   acc;
    logic [DATA_W-1:0]     dvs_mag;
    logic                  neg_q;
    logic                  neg_r;

    logic                  accept;
    logic                  abort;
    logic                  dvd_neg;
    logic                  dvs_neg;
    logic [DATA_W-1:0]     dvd_abs;
    logic [DATA_W-1:0]     dvs_abs;

    logic [2*DATA_W:0]     shifted;
    logic [DATA_W:0]       upper;
    logic [DATA_W:0]       trial;
    logic [2*DATA_W-1:0]   step_acc;

    logic [DATA_W-1:0]     quo;
    logic [DATA_W-1:0]     rem;
    logic [DATA_W-1:0]     quo_fix;
    logic [DATA_W-1:0]     rem_fix;

    assign accept = start && !annul;
    assign abort  = annul || !start;

    // Operand magnitudes; -2^31 maps to 0x80000000, which the unsigned
    // datapath handles directly.
    assign dvd_neg = signed_div && dividend[DATA_W-1];
    assign dvs_neg = signed_div && divisor[DATA_W-1];
    assign dvd_abs = dvd_neg ? -dividend : dividend;
    assign dvs_abs = dvs_neg ? -divisor  : divisor;

    // One restoring step. The partial remainder before the shift is always
    // below the divisor, so after the shift it is below twice the divisor and
    // the (DATA_W+1)-bit trial difference never overflows; its MSB is the
    // borrow.
    assign shifted  = {acc, 1'b0};
    assign upper    = shifted[2*DATA_W:DATA_W];
    assign trial    = upper - {1'b0, dvs_mag};
    assign step_acc = trial[DATA_W]
                    ? {upper[DATA_W-1:0], shifted[DATA_W-1:1], 1'b0}
                    : {trial[DATA_W-1:0], shifted[DATA_W-1:1], 1'b1};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = (divisor == '0) ? BY_ZERO : ON;
                end
            end
            BY_ZERO: begin
                state_nxt = abort ? IDLE : END;
            end
            ON: begin
                if (abort) begin
                    state_nxt = IDLE;
                end else if (cnt == LAST_STEP) begin
                    state_nxt = END;
                end
            end
            END: begin
                if (abort) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt     <= '0;
            acc     <= '0;
            dvs_mag <= '0;
            neg_q   <= 1'b0;
            neg_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        cnt     <= '0;
                        acc     <= {{DATA_W{1'b0}}, dvd_abs};
                        dvs_mag <= dvs_abs;
                        neg_q   <= dvd_neg ^ dvs_neg;
                        neg_r   <= dvd_neg;
                    end
                end
                ON: begin
                    acc <= step_acc;
                    cnt <= cnt + 1'b1;
                end
                BY_ZERO: begin
                    acc <= '0;
                end
                default: begin
                end
            endcase
        end
    end

    assign quo     = acc[DATA_W-1:0];
    assign rem     = acc[2*DATA_W-1:DATA_W];
    assign quo_fix = neg_q ? -quo : quo;
    assign rem_fix = neg_r ? -rem : rem;

    assign ready  = (state == END);
    assign result = (state == END) ? {rem_fix, quo_fix} : '0;

    // Gated by reset so the stall request is released the instant reset is
    // asserted, even if EX is still holding start.
    assign stop_req = reset && (((state == IDLE) && accept) ||
                                (state == BY_ZERO) ||
                                (state == ON));

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - randomized self-checking bench for div_unit

module tb_div_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        signed_div;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        annul;
    logic        stop_req;
    logic        ready;
    logic [63:0] result;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .signed_div (signed_div),
        .dividend   (dividend),
        .divisor    (divisor),
        .annul      (annul),
        .stop_req   (stop_req),
        .ready      (ready),
        .result     (result)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: plain integer division (truncating, remainder follows the
    // dividend's sign), with divide-by-zero defined as {0, 0}.
    function automatic logic [63:0] ref_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint q;
        longint r;
        longint sa;
        longint sb;
        if (b == 32'h0) return 64'h0;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'h0, a});
            sb = longint'({32'h0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called #0 after a negedge with start already high: this cycle is cycle 0.
    task automatic run_check(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        int          exp_lat;
        int          rdy_cyc;
        bit          stall_ok;
        logic [63:0] got_res;
        logic [63:0] exp_res;
        exp_lat  = (b == 32'h0) ? 2 : 33;
        exp_res  = ref_div(sgn, a, b);
        rdy_cyc  = -1;
        stall_ok = 1'b1;
        got_res  = 64'h0;
        for (int c = 0; c < 40; c++) begin
            #1;
            if (ready === 1'b1) begin
                rdy_cyc = c;
                got_res = result;
                if (stop_req !== 1'b0) stall_ok = 1'b0;
                break;
            end
            if (stop_req !== 1'b1) stall_ok = 1'b0;
            @(negedge clk);
            if (c == 0) begin
                dividend   = $urandom;
                divisor    = $urandom;
                signed_div = 1'($urandom);
            end
        end
        check({tag, " ready_cycle"}, 64'(rdy_cyc), 64'(exp_lat));
        check({tag, " stall"}, {63'h0, stall_ok}, 64'h1);
        check({tag, " result"}, got_res, exp_res);
        if (rdy_cyc >= 0) begin
            @(negedge clk);
            #1;
            check({tag, " hold"}, {ready, result[62:0]}, {1'b1, exp_res[62:0]});
            start = 1'b0;
            @(negedge clk);
            #1;
            check({tag, " idle"}, {63'h0, ready | stop_req} | result, 64'h0);
        end
    endtask

    task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b, input string tag);
        @(negedge clk);
        signed_div = sgn;
        dividend   = a;
        divisor    = b;
        annul      = 1'b0;
        start      = 1'b1;
        run_check(sgn, a, b, tag);
    endtask

    initial begin
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        bit          saw_ready;

        reset      = 1'b0;
        start      = 1'b0;
        signed_div = 1'b0;
        dividend   = 32'h0;
        divisor    = 32'h0;
        annul      = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("reset_state", {62'h0, ready, stop_req} | result, 64'h0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        check("idle_after_reset", {62'h0, ready, stop_req} | result, 64'h0);

        do_div(1'b0, 32'd100, 32'd7, "u100_7");
        do_div(1'b1, 32'hFFFF_FFF9, 32'd2, "s-7_2");
        do_div(1'b1, 32'd7, 32'hFFFF_FFFE, "s7_-2");
        do_div(1'b0, 32'h1234, 32'h0, "divzero");
        do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "smin_-1");
        do_div(1'b0, 32'hFFFF_FFFF, 32'd1, "umax_1");
        do_div(1'b0, 32'hFFFF_FFF9, 32'd2, "u_nosignconv");
        do_div(1'b0, 32'd5, 32'd9, "small_over_big");

        // annul in cycle 10 of 100/7
        saw_ready = 1'b0;
        @(negedge clk);
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        start      = 1'b1;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (ready === 1'b1) saw_ready = 1'b1;
            @(negedge clk);
        end
        annul = 1'b1;
        #1;
        if (ready === 1'b1) saw_ready = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        start = 1'b0;
        #1;
        check("annul_idle", {62'h0, ready | saw_ready, stop_req} | result, 64'h0);
        do_div(1'b0, 32'd100, 32'd7, "after_annul");

        // reset asserted at cycle 20, released with start still high
        @(negedge clk);
        signed_div = 1'b0;
        dividend   = 32'd100;
        divisor    = 32'd7;
        start      = 1'b1;
        repeat (20) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_reset", {62'h0, ready, stop_req} | result, 64'h0);
        @(negedge clk);
        dividend = 32'd100;
        divisor  = 32'd7;
        reset    = 1'b1;
        run_check(1'b0, 32'd100, 32'd7, "reset_restart");

        for (int i = 0; i < 40; i++) begin
            sgn = 1'($urandom);
            a   = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'h0;
                1:       b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = $urandom >> $urandom_range(8, 28);
            endcase
            if ($urandom_range(0, 3) == 0) a = a >> $urandom_range(16, 31);
            do_div(sgn, a, b, $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit signed/unsigned divider in the EX stage; the stall initiator for the pipeline controller.
- While a division is in flight it drives `stop_req` high; this output feeds the controller's EX stall-request input, which freezes PC/IF/ID/EX.
- Produces quotient and remainder for DIV/DIVU, which are written to HI/LO in a later stage.
- Latency is fixed: one restoring-division step per cycle.

Parameters:
- DATA_W, 32, operand width; the iteration count equals DATA_W.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- start  in  1  division request from EX; held high by EX until it sees ready.
- signed_div  in  1  1 = DIV (signed), 0 = DIVU.
- dividend  in  DATA_W  rs operand; sampled in IDLE when start=1.
- divisor  in  DATA_W  rt operand; sampled in IDLE when start=1.
- annul  in  1  cancel the in-flight division (flush or exception).
- stop_req  out  1  stall request to the controller.
- ready  out  1  result valid this cycle.
- result  out  2*DATA_W  {remainder[63:32], quotient[31:0]}.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, working registers=0.
  - ready=0, result=0, stop_req=0.
- States: IDLE, BY_ZERO, ON, END.
- IDLE:
  - start=1 and annul=0: capture operands. If signed_div=1, convert each negative operand to its magnitude and record the sign of each.
  - Then: if divisor==0, next state is BY_ZERO; otherwise next state is ON with cnt=0 and the 65-bit working register = {33'b0, |dividend|}.
- ON: one restoring step per cycle.
  - Shift the working register left by 1.
  - Trial-subtract |divisor| from the upper 33 bits.
  - If the difference is non-negative, keep it and set quotient LSB=1; otherwise restore and set LSB=0.
  - cnt increments each step. After the step with cnt=DATA_W-1, next state is END.
- BY_ZERO: next state is END, with quotient=0 and remainder=0.
- END:
  - ready=1. result holds the final value.
  - Signed correction: quotient is negated if the dividend and divisor signs differ; remainder takes the dividend's sign.
  - Stay in END while start=1. When start=0, go to IDLE.
- stop_req is combinational:
  - 1 when (IDLE and start=1 and annul=0), or in BY_ZERO, or in ON.
  - 0 in END, which lets the pipeline advance in the ready cycle.
- Latency, with cycle 0 the first cycle start is high in IDLE:
  - Normal division: ready in cycle 33; stop_req high in cycles 0..32.
  - Divide-by-zero: ready in cycle 2; stop_req high in cycles 0..1.
- annul=1, or start=0, while in ON or BY_ZERO: abort to IDLE on the next edge. ready never rises and stop_req drops on the next cycle.
- annul=1 in END: go to IDLE. The result in that cycle is ignored by EX.
- result=0 whenever state≠END. ready=1 only in END.
- Boundary case: signed -2^31 / -1 gives quotient 0x80000000 and remainder 0. The magnitude 2^31 fits the unsigned path, no negation is applied, and no trap is raised.
- Unsigned operands are never sign-converted. Operands that change after capture have no effect.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0.

Test Plan:
- Unsigned 100/7 (start held) -> stop_req=1 in cycles 0..32; ready=1 in cycle 33; result={32'd2, 32'd14}. Drop start -> IDLE, ready=0, result=0.
- Signed -7/2 -> quotient 0xFFFFFFFD (-3), remainder 0xFFFFFFFF (-1). Signed 7/-2 -> quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (dividend 0x1234) -> stop_req=1 in cycles 0..1; ready in cycle 2; result=64'h0.
- Signed 0x80000000/0xFFFFFFFF -> quotient 0x80000000, remainder 0. Unsigned 0xFFFFFFFF/1 -> quotient 0xFFFFFFFF, remainder 0.
- annul pulse in cycle 10 of 100/7 -> IDLE at cycle 11; stop_req=0 from cycle 11; ready never asserts. A new start at cycle 12 completes normally at cycle 45.
- Assert reset=0 at cycle 20 -> ready, stop_req and result go 0 immediately. Release reset with start=1 -> the division restarts from cycle 0.
